// File: rtl/shot_sequencer.sv
// -----------------------------------------------------------------------------
// shot_sequencer
// Round-level controller for the ball motion datapath. Turns mouse clicks into
// single-cycle launch pulses, tracks flight and landing from the motion block's
// z-negative flag, frames the collision settle/check window, and keeps the shot
// budget and the saturating score.
//
// State table (o_state code | meaning)
//   0 IDLE      | waiting for a launch edge, shots available
//   1 FLIGHT    | ball in the air, counting frames until landing or timeout
//   2 SETTLE    | ball landed and held, waiting SETTLE_FRAMES ticks
//   3 CHECK     | waiting for a collision result or CHECK_TIMEOUT ticks
//   4 SCORE     | one cycle: apply captured hit to the score
//   5 RECOVER   | one cycle: collision_done to motion, then IDLE/GAME_OVER
//   6 GAME_OVER | no shots left, only restart leaves
//
// Ports
//   i_clk, i_rst_n        clock, async active-low reset
//   i_mouse_left          button level (synchronous)
//   i_refresh             one-cycle frame tick
//   i_z_neg               ball below ground
//   i_restart             one-cycle new-game request (top priority)
//   i_hit_valid/i_hit/i_hit_pts  collision result strobe, flag and points
//   o_launch              one-cycle launch pulse
//   o_en_collision        hold ball / enable collision detection
//   o_collision_done      one-cycle clear to motion
//   o_shots_left, o_score, o_score_pulse, o_game_over, o_state
// All outputs are registered.
// -----------------------------------------------------------------------------
module shot_sequencer #(
  parameter int SHOTS          = 10,
  parameter int SETTLE_FRAMES  = 60,
  parameter int CHECK_TIMEOUT  = 4,
  parameter int FLIGHT_TIMEOUT = 255,
  parameter int SCORE_W        = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_mouse_left,
  input  logic               i_refresh,
  input  logic               i_z_neg,
  input  logic               i_restart,
  input  logic               i_hit_valid,
  input  logic               i_hit,
  input  logic [3:0]         i_hit_pts,
  output logic               o_launch,
  output logic               o_en_collision,
  output logic               o_collision_done,
  output logic [3:0]         o_shots_left,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_score_pulse,
  output logic               o_game_over,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FLIGHT    = 3'd1,
    SETTLE    = 3'd2,
    CHECK     = 3'd3,
    SCORE     = 3'd4,
    RECOVER   = 3'd5,
    GAME_OVER = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               mouse_prev_q;
  logic [3:0]         shots_q, shots_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               hit_q, hit_d;
  logic [3:0]         pts_q, pts_d;
  logic               launch_q, launch_d;
  logic               en_q, en_d;
  logic               done_q, done_d;
  logic               pulse_q, pulse_d;
  logic               over_q, over_d;

  logic               launch_edge;
  logic [SCORE_W:0]   score_sum;
  logic [7:0]         cnt_inc;

  assign launch_edge = i_mouse_left & ~mouse_prev_q;
  // One extra bit catches the carry so the score can clamp instead of wrapping.
  assign score_sum   = {1'b0, score_q} + {{(SCORE_W-3){1'b0}}, pts_q};
  // Frame counter saturates rather than wrapping.
  assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shots_d  = shots_q;
    score_d  = score_q;
    hit_d    = hit_q;
    pts_d    = pts_q;
    launch_d = 1'b0;
    pulse_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (launch_edge && shots_q != 4'd0) begin
          launch_d = 1'b1;
          shots_d  = shots_q - 4'd1;
          state_d  = FLIGHT;
        end
      end
      FLIGHT: begin
        if (i_refresh && i_z_neg) begin
          state_d = SETTLE;
        end else if (cnt_q >= 8'(FLIGHT_TIMEOUT)) begin
          state_d = RECOVER;
        end else if (i_refresh) begin
          cnt_d = cnt_inc;
        end
      end
      SETTLE: begin
        if (i_refresh) begin
          if (cnt_q >= 8'(SETTLE_FRAMES - 1)) state_d = CHECK;
          else                                cnt_d   = cnt_inc;
        end
      end
      CHECK: begin
        // A result arriving on the timeout tick still counts.
        if (i_hit_valid) begin
          hit_d   = i_hit;
          pts_d   = i_hit_pts;
          state_d = SCORE;
        end else if (i_refresh) begin
          if (cnt_q >= 8'(CHECK_TIMEOUT - 1)) state_d = RECOVER;
          else                                cnt_d   = cnt_inc;
        end
      end
      SCORE: begin
        if (hit_q) begin
          score_d = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
          pulse_d = 1'b1;
        end
        state_d = RECOVER;
      end
      RECOVER: begin
        state_d = (shots_q != 4'd0) ? IDLE : GAME_OVER;
      end
      GAME_OVER: begin
        state_d = GAME_OVER;
      end
      default: state_d = IDLE;
    endcase

    if (i_restart) begin
      state_d  = IDLE;
      score_d  = '0;
      shots_d  = 4'(SHOTS);
      launch_d = 1'b0;
      pulse_d  = 1'b0;
    end

    if (state_d != state_q) cnt_d = 8'd0;

    // Output registers follow the next state so they line up with o_state.
    done_d = (state_d == RECOVER) || i_restart;
    en_d   = (state_d == SETTLE) || (state_d == CHECK) || (state_d == SCORE);
    over_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      mouse_prev_q <= 1'b0;
      shots_q      <= 4'(SHOTS);
      score_q      <= '0;
      hit_q        <= 1'b0;
      pts_q        <= 4'd0;
      launch_q     <= 1'b0;
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      pulse_q      <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mouse_prev_q <= i_mouse_left;
      shots_q      <= shots_d;
      score_q      <= score_d;
      hit_q        <= hit_d;
      pts_q        <= pts_d;
      launch_q     <= launch_d;
      en_q         <= en_d;
      done_q       <= done_d;
      pulse_q      <= pulse_d;
      over_q       <= over_d;
    end
  end

  assign o_launch         = launch_q;
  assign o_en_collision   = en_q;
  assign o_collision_done = done_q;
  assign o_shots_left     = shots_q;
  assign o_score          = score_q;
  assign o_score_pulse    = pulse_q;
  assign o_game_over      = over_q;
  assign o_state          = state_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shot_sequencer
// Scoreboarded bench for shot_sequencer. Expected shots/score at every launch
// and collision_done pulse are queued when the stimulus is driven and compared
// by a negedge monitor when the pulse appears. Score width is reduced to 6 bits
// so saturation is reachable within one 10-shot game.
// -----------------------------------------------------------------------------
module tb_shot_sequencer;

  localparam int SW   = 6;
  localparam int SMAX = (1 << SW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_mouse_left, i_refresh, i_z_neg, i_restart;
  logic          i_hit_valid, i_hit;
  logic [3:0]    i_hit_pts;
  logic          o_launch, o_en_collision, o_collision_done;
  logic [3:0]    o_shots_left;
  logic [SW-1:0] o_score;
  logic          o_score_pulse, o_game_over;
  logic [2:0]    o_state;

  shot_sequencer #(.SCORE_W(SW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mouse_left(i_mouse_left),
    .i_refresh(i_refresh), .i_z_neg(i_z_neg), .i_restart(i_restart),
    .i_hit_valid(i_hit_valid), .i_hit(i_hit), .i_hit_pts(i_hit_pts),
    .o_launch(o_launch), .o_en_collision(o_en_collision),
    .o_collision_done(o_collision_done), .o_shots_left(o_shots_left),
    .o_score(o_score), .o_score_pulse(o_score_pulse),
    .o_game_over(o_game_over), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {int score; int shots;} done_t;
  done_t done_exp_q[$];
  int    launch_exp_q[$];

  int n_checks = 0, n_errors = 0;
  int exp_score = 0, exp_shots = 10, exp_pulses = 0, exp_launches = 0;
  int seen_pulses = 0, seen_launches = 0;
  done_t d_pop;
  int    l_pop;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_launch) begin
        seen_launches++;
        if (launch_exp_q.size() == 0) chk("launch_unexpected", launch_exp_q.size(), 1);
        else begin
          l_pop = launch_exp_q.pop_front();
          chk("launch_shots", o_shots_left, l_pop);
        end
      end
      if (o_collision_done) begin
        if (done_exp_q.size() == 0) chk("done_unexpected", done_exp_q.size(), 1);
        else begin
          d_pop = done_exp_q.pop_front();
          chk("done_score", o_score, d_pop.score);
          chk("done_shots", o_shots_left, d_pop.shots);
        end
      end
      if (o_score_pulse) seen_pulses++;
    end
  end

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic frame(input logic z);
    i_refresh = 1'b1; i_z_neg = z; step();
    i_refresh = 1'b0; i_z_neg = 1'b0; step();
  endtask

  task automatic press(input int hold);
    exp_shots--; exp_launches++;
    launch_exp_q.push_back(exp_shots);
    i_mouse_left = 1'b1; step();
    chk("launch_state", o_state, 1);
    chk("launch_pulse", o_launch, 1);
    step();
    chk("launch_width", o_launch, 0);
    for (int i = 0; i < hold; i++) step();
    i_mouse_left = 1'b0;
  endtask

  task automatic land(input int n);
    for (int i = 0; i < n - 1; i++) frame(1'b0);
    chk("flight_en", o_en_collision, 0);
    frame(1'b1);
    chk("settle_state", o_state, 2);
    chk("settle_en", o_en_collision, 1);
  endtask

  task automatic settle();
    for (int i = 0; i < 59; i++) frame(1'b0);
    chk("settle_hold", o_state, 2);
    frame(1'b0);
    chk("check_state", o_state, 3);
    chk("check_en", o_en_collision, 1);
  endtask

  task automatic push_done(input logic hit, input int pts);
    done_t d;
    if (hit) begin
      exp_score = (exp_score + pts > SMAX) ? SMAX : exp_score + pts;
      exp_pulses++;
    end
    d.score = exp_score; d.shots = exp_shots;
    done_exp_q.push_back(d);
  endtask

  task automatic back_to_rest();
    int k = 0;
    while (!(o_state == 3'd0 || o_state == 3'd6) && k < 8) begin step(); k++; end
    chk("rest_reached", (o_state == 3'd0 || o_state == 3'd6), 1);
    chk("rest_en", o_en_collision, 0);
  endtask

  // mode 0: result now, 1: timeout miss, 2: result on the timeout tick
  task automatic resolve(input int mode, input logic hit, input int pts);
    push_done(hit && mode != 1, pts);
    if (mode != 0) for (int i = 0; i < 3; i++) frame(1'b0);
    if (mode == 1) begin
      chk("check_wait", o_state, 3);
      frame(1'b0);
    end else begin
      i_refresh = (mode == 2); i_hit_valid = 1'b1; i_hit = hit; i_hit_pts = 4'(pts);
      step();
      i_refresh = 1'b0; i_hit_valid = 1'b0; i_hit = 1'b0; i_hit_pts = 4'd0;
      chk("score_state", o_state, 4);
      step();
      chk("recover_state", o_state, 5);
    end
    back_to_rest();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_mouse_left = 0; i_refresh = 0; i_z_neg = 0;
    i_restart = 0; i_hit_valid = 0; i_hit = 0; i_hit_pts = 0;
    step(); step();
    i_rst_n = 1'b1;
    step();
    chk("rst_state", o_state, 0);
    chk("rst_shots", o_shots_left, 10);
    chk("rst_score", o_score, 0);
    chk("rst_launch", o_launch, 0);
    chk("rst_over", o_game_over, 0);

    // shot 1: held button, land on 20th tick, hit for 5
    press(100);
    land(20); settle(); resolve(0, 1'b1, 5);
    chk("score_after_hit", o_score, 5);
    // shot 2: stray result in flight ignored, timeout miss
    press(0);
    i_hit_valid = 1; i_hit = 1; i_hit_pts = 4'd15; step();
    i_hit_valid = 0; i_hit = 0; i_hit_pts = 0;
    chk("stray_hit_state", o_state, 1);
    land(5); settle(); resolve(1, 1'b0, 0);
    // shot 3: result coincident with 4th tick
    press(0); land(3); settle(); resolve(2, 1'b1, 7);
    // shot 4: never lands
    press(0);
    push_done(1'b0, 0);
    for (int i = 0; i < 255; i++) frame(1'b0);
    back_to_rest();
    chk("timeout_shots", o_shots_left, 6);
    // shot 5: result says miss
    press(0); land(1); settle(); resolve(0, 1'b0, 9);
    // shots 6..10: max points, saturates on shot 9
    for (int s = 0; s < 5; s++) begin
      press(0); land(2); settle(); resolve(0, 1'b1, 15);
    end
    chk("sat_score", o_score, SMAX);
    chk("over_state", o_state, 6);
    chk("over_flag", o_game_over, 1);
    i_mouse_left = 1; step(); step();
    chk("over_no_launch", o_state, 6);
    i_mouse_left = 0; step();

    // restart from game over
    exp_score = 0; exp_shots = 10;
    push_done(1'b0, 0);
    i_restart = 1; step(); i_restart = 0;
    chk("restart_state", o_state, 0);
    chk("restart_shots", o_shots_left, 10);
    chk("restart_score", o_score, 0);
    chk("restart_done", o_collision_done, 1);
    chk("restart_over", o_game_over, 0);

    // restart mid-settle
    press(0); land(2);
    for (int i = 0; i < 10; i++) frame(1'b0);
    exp_shots = 10; push_done(1'b0, 0);
    i_restart = 1; step(); i_restart = 0;
    chk("rs_settle_state", o_state, 0);
    chk("rs_settle_en", o_en_collision, 0);
    chk("rs_settle_done", o_collision_done, 1);
    chk("rs_settle_shots", o_shots_left, 10);

    // async reset mid-check
    press(0); land(4); settle();
    @(posedge i_clk); #3;
    i_rst_n = 1'b0; #1;
    chk("arst_state", o_state, 0);
    chk("arst_shots", o_shots_left, 10);
    chk("arst_en", o_en_collision, 0);
    chk("arst_done", o_collision_done, 0);
    chk("arst_score", o_score, 0);
    step(); i_rst_n = 1'b1; step();

    chk("pulse_count", seen_pulses, exp_pulses);
    chk("launch_count", seen_launches, exp_launches);
    chk("done_q_empty", done_exp_q.size(), 0);
    chk("launch_q_empty", launch_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shot_sequencer.md
Name: shot_sequencer

Overview:
Round-level controller for the ball motion datapath. It turns mouse clicks into single-cycle launch pulses and tracks flight and landing from the motion block's z-negative flag. It drives the motion block's collision-enable and collision-done controls around the settle and scoring window. It also keeps the shot budget and the score, and sits between the mouse interface, motion, the collision detector and the score display.

Parameters:
SHOTS, 10, shots per game (1..15)
SETTLE_FRAMES, 60, refresh ticks to wait after landing before the collision check
CHECK_TIMEOUT, 4, refresh ticks to wait for a collision result before declaring a miss
FLIGHT_TIMEOUT, 255, refresh ticks allowed in flight before a forced miss (1..255)
SCORE_W, 8, score width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_mouse_left  in  1  mouse left button, level, synchronous to i_clk
i_refresh  in  1  one-cycle frame tick
i_z_neg  in  1  from motion: ball below ground (landed)
i_restart  in  1  one-cycle new-game request
i_hit_valid  in  1  one-cycle collision result strobe
i_hit  in  1  result: 1 = target hit
i_hit_pts  in  4  points for this hit
o_launch  out  1  one-cycle launch pulse to motion
o_en_collision  out  1  hold ball and enable collision detection
o_collision_done  out  1  one-cycle clear to motion
o_shots_left  out  4  remaining shots
o_score  out  SCORE_W  accumulated score
o_score_pulse  out  1  one-cycle pulse when the score is updated
o_game_over  out  1  high in GAME_OVER
o_state  out  3  current state code

Behaviour:
- Clock/reset: single clock i_clk; i_rst_n is asynchronous, active-low.
- Reset values: state IDLE, o_shots_left = SHOTS, o_score = 0, all pulses 0, internal mouse-previous register 0, frame counter 0.
- Outputs: all registered.
- State codes: IDLE=0, FLIGHT=1, SETTLE=2, CHECK=3, SCORE=4, RECOVER=5, GAME_OVER=6.
- Launch edge detect: a launch edge is i_mouse_left=1 with the previous sample 0. The previous-sample register updates every cycle in every state, so a button held across a return to IDLE does not launch.
- IDLE: on a launch edge with shots_left>0, o_launch=1 for the next cycle only, shots_left decrements, and the state goes to FLIGHT in that same next cycle. Edges in any other state are ignored.
- FLIGHT: the frame counter counts i_refresh ticks.
  - On an i_refresh cycle with i_z_neg=1: go to SETTLE and clear the counter.
  - Otherwise, when the counter reaches FLIGHT_TIMEOUT: miss, go to RECOVER.
- SETTLE: o_en_collision=1. When the counter reaches SETTLE_FRAMES-1 on an i_refresh cycle, go to CHECK and clear the counter. o_en_collision is high no later than motion's own hold-window expiry.
- CHECK: o_en_collision=1.
  - i_hit_valid=1: capture i_hit and i_hit_pts, go to SCORE.
  - Otherwise, CHECK_TIMEOUT i_refresh ticks elapsed: miss, go to RECOVER.
  - i_hit_valid takes priority over a timeout in the same cycle.
- SCORE: o_en_collision=1 for one cycle.
  - If the captured hit=1: score = min(score + pts, 2^SCORE_W-1) (saturating), and o_score_pulse=1 for that cycle.
  - Then go to RECOVER.
- RECOVER: o_collision_done=1 for exactly one cycle. Next state is IDLE if shots_left>0, else GAME_OVER.
- GAME_OVER: o_game_over=1; launch edges are ignored.
- i_restart has top priority in every state:
  - Next cycle: state IDLE, score 0, shots_left=SHOTS, o_collision_done=1 for one cycle, o_en_collision=0.
  - Restart mid-flight discards the shot in progress.
- i_hit_valid outside CHECK is ignored.
- o_en_collision=0 in IDLE, FLIGHT, RECOVER and GAME_OVER.
- The frame counter is 8 bits and never wraps: it saturates at 255, and every state entry clears it.
- Worst-case latency:
  - launch edge to o_launch: 1 cycle.
  - landing tick to CHECK: SETTLE_FRAMES ticks.
  - CHECK to o_collision_done: at most 2 cycles after the result.

Test Plan:
1. Reset, then a launch edge -> o_launch high exactly 1 cycle, o_state=1, o_shots_left 10→9. Holding the button for 100 cycles produces no second pulse.
2. After launch, i_z_neg=1 on the 20th tick -> SETTLE with o_en_collision=1. After 60 ticks -> CHECK. i_hit_valid, i_hit=1, pts=5 -> o_score=5, o_score_pulse once, o_collision_done 1 cycle, back to IDLE.
3. In CHECK, no i_hit_valid for 4 ticks -> miss: score unchanged, o_collision_done pulse, IDLE. Same test with i_hit_valid coincident with the 4th tick -> hit is scored.
4. Ball never lands -> FLIGHT_TIMEOUT (255 ticks) forces RECOVER, then IDLE; shots_left stays decremented.
5. Run 10 shots -> after the last RECOVER, o_game_over=1, o_state=6, and launch edges are ignored. i_restart -> IDLE, shots 10, score 0.
6. Preload score 250 and hit with pts=15 -> score saturates at 255. Then i_restart mid-SETTLE -> o_collision_done pulse, o_en_collision=0, IDLE. Then async reset asserted mid-CHECK -> all outputs at reset values immediately.
